// File: rtl/shift_pkg.sv
// Shared types for the iterative shifter: op encodings, FSM states,
// and the per-cycle step clamp.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Bits to shift this cycle: never more than what is left.
    function automatic int unsigned clamp_step(
        input int unsigned rem,
        input int unsigned step
    );
        return (rem < step) ? rem : step;
    endfunction

endpackage

// File: rtl/iterative_shift_unit_if.sv
// EX-stage shifter request/response bundle.
// master: pipeline side (start/flush/op/operand/shamt_ext out;
//   busy/stall_req/done/result/amt_ovf in). slave: the shifter.
interface iterative_shift_unit_if
    import shift_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              start;
    logic              flush;
    op_e               op;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] shamt_ext;
    logic              busy;
    logic              stall_req;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              amt_ovf;

    modport master (
        output start, flush, op, operand, shamt_ext,
        input  busy, stall_req, done, result, amt_ovf
    );

    modport slave (
        input  start, flush, op, operand, shamt_ext,
        output busy, stall_req, done, result, amt_ovf
    );
endinterface

// File: rtl/shift_step.sv
// Combinational single step: shifts acc by k (k <= STEP) per op.
// Ports: acc, op, k in; res out. ROTR only with SHIFT_ROTR_EN.
module shift_step
    import shift_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [DATA_W-1:0]  acc,
    input  op_e                op,
    input  logic [SHAMT_W-1:0] k,
    output logic [DATA_W-1:0]  res
);
    always_comb begin
        res = acc >> k;
        case (op)
            OP_SLL:  res = acc << k;
            OP_SRA:  res = $signed(acc) >>> k;
`ifdef SHIFT_ROTR_EN
            // k==0 gives acc<<DATA_W == 0, so the OR is harmless.
            OP_ROTR: res = (acc >> k)
                         | (acc << (DATA_W - int'(k)));
`endif
            default: res = acc >> k;
        endcase
    end
endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle SLL/SRL/SRA(/ROTR with SHIFT_ROTR_EN) shifter for EX.
// Ports: Clk, Rst_n, bus (slave): start/flush/op/operand/shamt_ext in,
//   busy/stall_req/done/result/amt_ovf out.
module iterative_shift_unit
    import shift_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    iterative_shift_unit_if.slave bus
);
    state_e             state_q, state_d;
    logic [DATA_W-1:0]  acc_q;
    logic [DATA_W-1:0]  result_q;
    logic [DATA_W-1:0]  step_res;
    op_e                op_q;
    logic [SHAMT_W-1:0] rem_q;
    logic [SHAMT_W-1:0] k;
    logic               done_q;
    logic               ovf_q;
    logic               accept;

    assign accept = (state_q == IDLE) & bus.start & ~bus.flush;
    assign k = SHAMT_W'(clamp_step(32'(rem_q), STEP));

    shift_step #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .acc (acc_q),
        .op  (op_q),
        .k   (k),
        .res (step_res)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            result_q <= '0;
            op_q     <= OP_SLL;
            rem_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_q <= bus.operand;
                        op_q  <= bus.op;
                        rem_q <= bus.shamt_ext[SHAMT_W-1:0];
                        ovf_q <= |bus.shamt_ext[DATA_W-1:SHAMT_W];
                    end
                end
                SHIFT: begin
                    if (!bus.flush && rem_q != '0) begin
                        acc_q <= step_res;
                        rem_q <= rem_q - k;
                    end
                end
                DONE: begin
                    // Registered so result and done appear together.
                    if (!bus.flush) begin
                        result_q <= acc_q;
                        done_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                if (bus.flush)        state_d = IDLE;
                else if (rem_q == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q == SHIFT);
    assign bus.stall_req = ((state_q == IDLE) & bus.start)
                         | (state_q == SHIFT);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.amt_ovf   = ovf_q;
endmodule

// File: tb/tb_iterative_shift_unit.sv
// Scoreboard bench for iterative_shift_unit (STEP=1).
// Directed vectors; monitor pops expectations on each done pulse.
module tb_iterative_shift_unit;
    import shift_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iterative_shift_unit_if #(.DATA_W(32)) bus();

    iterative_shift_unit #(
        .DATA_W  (32),
        .SHAMT_W (5),
        .STEP    (1)
    ) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc++;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'b0, bus.done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_res"}, bus.result, e.res);
                chk({e.name, "_ovf"}, {31'b0, bus.amt_ovf},
                    {31'b0, e.ovf});
                chk({e.name, "_lat"}, cyc - e.acc, e.lat);
            end
        end
    end

    task automatic wait_drain(string nm);
        for (int i = 0; i < 100 && sb.size() != 0; i++)
            @(negedge clk);
        chk({"drain_", nm}, sb.size(), 32'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic push(string nm, logic [31:0] r, logic ovf, int lat);
        exp_t e;
        e = '{res: r, ovf: ovf, lat: lat, acc: cyc + 1, name: nm};
        sb.push_back(e);
    endtask

    task automatic drive(logic [1:0] o, logic [31:0] a, logic [31:0] s);
        bus.start     = 1'b1;
        bus.op        = op_e'(o);
        bus.operand   = a;
        bus.shamt_ext = s;
    endtask

    task automatic issue(string nm, logic [1:0] o, logic [31:0] a,
                         logic [31:0] s, logic [31:0] r, logic ovf,
                         int lat);
        @(negedge clk);
        drive(o, a, s);
        push(nm, r, ovf, lat);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.operand   = 32'hA5A5A5A5;
        bus.shamt_ext = 32'h0000001F;
        wait_drain(nm);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.op        = OP_SLL;
        bus.operand   = '0;
        bus.shamt_ext = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy",   {31'b0, bus.busy},      32'd0);
        chk("rst_done",   {31'b0, bus.done},      32'd0);
        chk("rst_result", bus.result,             32'd0);
        chk("rst_ovf",    {31'b0, bus.amt_ovf},   32'd0);
        chk("rst_stall",  {31'b0, bus.stall_req}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue("sll31", 2'b00, 32'h1, 32'h1F, 32'h80000000, 1'b0, 33);
        issue("sra4", 2'b10, 32'h80000000, 32'h4, 32'hF8000000, 1'b0, 6);
        issue("srl4", 2'b01, 32'h80000000, 32'h4, 32'h08000000, 1'b0, 6);
        issue("sll_ovf", 2'b00, 32'h1, 32'h25, 32'h20, 1'b1, 7);
        issue("sra31n", 2'b10, 32'h80000000, 32'h1F,
              32'hFFFFFFFF, 1'b0, 33);
        issue("sra31p", 2'b10, 32'h7FFFFFFF, 32'h1F, 32'h0, 1'b0, 33);
`ifdef SHIFT_ROTR_EN
        issue("rotr1", 2'b11, 32'h1, 32'h1, 32'h80000000, 1'b0, 3);
        issue("rotr4", 2'b11, 32'h80000001, 32'h4,
              32'h18000000, 1'b0, 6);
`else
        issue("rotr1", 2'b11, 32'h1, 32'h1, 32'h0, 1'b0, 3);
        issue("rotr4", 2'b11, 32'h80000001, 32'h4,
              32'h08000000, 1'b0, 6);
`endif

        // Zero shift: one SHIFT cycle, then DONE, done two edges later.
        @(negedge clk);
        drive(2'b01, 32'hDEADBEEF, 32'h0);
        push("srl0", 32'hDEADBEEF, 1'b0, 2);
        #1;
        chk("stall_req_idle", {31'b0, bus.stall_req}, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("busy_shift0",  {31'b0, bus.busy},      32'd1);
        chk("stall_shift0", {31'b0, bus.stall_req}, 32'd1);
        @(negedge clk);
        #1;
        chk("busy_done0",  {31'b0, bus.busy},      32'd0);
        chk("stall_done0", {31'b0, bus.stall_req}, 32'd0);
        chk("early_done0", {31'b0, bus.done},      32'd0);
        wait_drain("srl0");

        // Flush while in DONE: no pulse, result held.
        @(negedge clk);
        drive(2'b00, 32'h12345678, 32'h0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        repeat (5) @(negedge clk);
        chk("flush_done_res", bus.result, 32'hDEADBEEF);

        // Flush and start together in IDLE: nothing accepted.
        @(negedge clk);
        drive(2'b00, 32'h1, 32'h3);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        #1;
        chk("flush_idle_busy", {31'b0, bus.busy}, 32'd0);
        repeat (6) @(negedge clk);

        // Flush on third SHIFT cycle; start while busy ignored.
        @(negedge clk);
        drive(2'b00, 32'h1, 32'hA);
        @(negedge clk);
        drive(2'b01, 32'h0000FFFF, 32'h0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("flush_shift_busy", {31'b0, bus.busy}, 32'd0);
        chk("flush_shift_res",  bus.result,        32'hDEADBEEF);
        repeat (20) @(negedge clk);
        chk("flush_shift_res2", bus.result, 32'hDEADBEEF);

        issue("srl_after", 2'b01, 32'hF0, 32'h4, 32'h0F, 1'b0, 6);

        // Reset mid-SHIFT clears everything; no done afterwards.
        @(negedge clk);
        drive(2'b00, 32'hFF, 32'h28);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("pre_rst_ovf", {31'b0, bus.amt_ovf}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   {31'b0, bus.busy},      32'd0);
        chk("mid_rst_done",   {31'b0, bus.done},      32'd0);
        chk("mid_rst_result", bus.result,             32'd0);
        chk("mid_rst_ovf",    {31'b0, bus.amt_ovf},   32'd0);
        chk("mid_rst_stall",  {31'b0, bus.stall_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_result", bus.result, 32'd0);

        issue("sll1", 2'b00, 32'h3, 32'h1, 32'h6, 1'b0, 3);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
